// File: rtl/alu_share_arbiter_if.sv
// Handshake and operand/result bus between the two requesting engines and the
// shared-ALU arbiter. The requesters drive through 'master'; the arbiter is the 'slave'.
interface alu_share_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req0_opc;
    logic [2:0]  req1_opc;
    logic [15:0] req0_a;
    logic [15:0] req1_a;
    logic [15:0] req0_b;
    logic [15:0] req1_b;
    logic        req0_c;
    logic        req1_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_zer;
    logic        rsp_neg;

    modport master (
        output req_valid, req0_opc, req1_opc, req0_a, req1_a,
               req0_b, req1_b, req0_c, req1_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zer, rsp_neg
    );

    modport slave (
        input  req_valid, req0_opc, req1_opc, req0_a, req1_a,
               req0_b, req1_b, req0_c, req1_c, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zer, rsp_neg
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational 16-bit ALU between two requesters:
// accept in IDLE, compute in EXEC, hold the tagged result in RESP until consumed.
module alu_share_arbiter #(
    parameter logic FIRST_PRIO = 1'b0,
    parameter int   CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [2:0]         opc_q;
    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic               c_q;
    logic               id_q;
    logic [15:0]        alu_out;
    logic signed [15:0] b_sra;
    logic [15:0]        rsp_data_q;
    logic               rsp_id_q;
    logic               rsp_zer_q;
    logic               rsp_neg_q;

    // Contention goes to whoever was not served last; a lone request always wins.
    always_comb begin
        grant = 1'b0;
        if (bus.req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (bus.req_valid == 2'b11) begin
            grant = ~last_grant;
        end
    end

    always_comb begin
        accept        = (state == IDLE) && (bus.req_valid != 2'b00);
        bus.req_ready = 2'b00;
        if (accept && rst_n) begin
            bus.req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        b_sra   = $signed(b_q) >>> 1;
        alu_out = 16'h0000;
        case (opc_q)
            3'b000:  alu_out = ~a_q + 16'd1;
            3'b001:  alu_out = a_q + 16'd1;
            3'b010:  alu_out = a_q + b_q + {15'd0, c_q};
            3'b011:  alu_out = a_q + b_sra;
            3'b100:  alu_out = a_q & b_q;
            3'b101:  alu_out = a_q | b_q;
            3'b110:  alu_out = {a_q[7:0], b_q[7:0]};
            default: alu_out = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ~FIRST_PRIO;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (state == RESP && bus.rsp_ready) begin
                last_grant <= rsp_id_q;
                if (op_count != {CNT_W{1'b1}}) begin
                    op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Only the granted requester's fields are muxed in, so the loser's inputs never matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q      <= 3'b000;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            c_q        <= 1'b0;
            id_q       <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_id_q   <= 1'b0;
            rsp_zer_q  <= 1'b0;
            rsp_neg_q  <= 1'b0;
        end else begin
            if (accept) begin
                opc_q <= grant ? bus.req1_opc : bus.req0_opc;
                a_q   <= grant ? bus.req1_a   : bus.req0_a;
                b_q   <= grant ? bus.req1_b   : bus.req0_b;
                c_q   <= grant ? bus.req1_c   : bus.req0_c;
                id_q  <= grant;
            end
            if (state == EXEC) begin
                rsp_data_q <= alu_out;
                rsp_id_q   <= id_q;
                rsp_zer_q  <= (alu_out == 16'h0000);
                rsp_neg_q  <= alu_out[15];
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zer   = rsp_zer_q;
    assign bus.rsp_neg   = rsp_neg_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a predictor pushes expected results at
// accept time, a monitor pops and compares whenever a response is presented.
module tb_alu_share_arbiter;

    localparam logic FIRST_PRIO = 1'b0;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        zer;
        logic        neg;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        busy_s;
    logic [15:0] op_count;
    logic [1:0]  op_count_s;

    exp_t        sbq[$];
    exp_t        done_q[$];
    logic        model_last;
    int          model_count;
    int          cyc;
    int          n_checks;
    int          n_fail;

    alu_share_arbiter_if ifm();
    alu_share_arbiter_if ifs();

    alu_share_arbiter #(.FIRST_PRIO(FIRST_PRIO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifm.slave), .busy(busy), .op_count(op_count)
    );

    // Second copy with a 2-bit counter sees identical stimulus to exercise saturation.
    alu_share_arbiter #(.FIRST_PRIO(FIRST_PRIO), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs.slave), .busy(busy_s), .op_count(op_count_s)
    );

    assign ifs.req_valid = ifm.req_valid;
    assign ifs.req0_opc  = ifm.req0_opc;
    assign ifs.req1_opc  = ifm.req1_opc;
    assign ifs.req0_a    = ifm.req0_a;
    assign ifs.req1_a    = ifm.req1_a;
    assign ifs.req0_b    = ifm.req0_b;
    assign ifs.req1_b    = ifm.req1_b;
    assign ifs.req0_c    = ifm.req0_c;
    assign ifs.req1_c    = ifm.req1_c;
    assign ifs.rsp_ready = ifm.rsp_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_alu(input logic [2:0] opc, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        case (opc)
            3'd0:    r = -sa;
            3'd1:    r = sa + 1;
            3'd2:    r = sa + sb + int'(c);
            3'd3:    r = sa + ((sb - (sb & 1)) / 2);
            3'd4:    r = int'(a & b);
            3'd5:    r = int'(a | b);
            3'd6:    r = int'(a[7:0]) * 256 + int'(b[7:0]);
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic logic winner(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
        return !last;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flushModel();
        sbq.delete();
        model_last  = ~FIRST_PRIO;
        model_count = 0;
    endtask

    task automatic driveInputs(input logic [1:0] v,
                               input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                               input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                               input logic rr);
        ifm.req_valid = v;
        ifm.rsp_ready = rr;
        if (v[0]) begin
            ifm.req0_opc = o0; ifm.req0_a = a0; ifm.req0_b = b0; ifm.req0_c = c0;
        end else begin
            ifm.req0_opc = 'x; ifm.req0_a = 'x; ifm.req0_b = 'x; ifm.req0_c = 'x;
        end
        if (v[1]) begin
            ifm.req1_opc = o1; ifm.req1_a = a1; ifm.req1_b = b1; ifm.req1_c = c1;
        end else begin
            ifm.req1_opc = 'x; ifm.req1_a = 'x; ifm.req1_b = 'x; ifm.req1_c = 'x;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                                 input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                                 input logic rr);
        @(posedge clk);
        #1;
        driveInputs(v, o0, a0, b0, c0, o1, a1, b1, c1, rr);
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) applyStimulus(2'b00, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, rr);
    endtask

    // Called a few ns after a rising edge; contention is pending when rst_n releases.
    task automatic resetMidFlight(input int ndone);
        driveInputs(2'b11, 3'd1, 16'h0000, 16'h0, 1'b0, 3'd1, 16'h4000, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        flushModel();
        #1;
        checkOutput("rst_rsp_valid", ifm.rsp_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_op_count", op_count, 16'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        ifm.rsp_ready = 1'b1;
        idle(4, 1'b1);
        checkOutput("rst_no_stale_rsp", done_q.size(), ndone + 1);
        checkOutput("rst_first_prio_id", done_q[$].id, FIRST_PRIO);
        checkOutput("rst_first_prio_data", done_q[$].data, 16'h0001);
        checkOutput("rst_op_count_after", op_count, 16'd1);
    endtask

    // Predictor: decides who should be granted and records the expected response.
    initial begin
        logic [1:0] er;
        logic       g;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("req_ready_in_reset", ifm.req_ready, 2'b00);
            end else begin
                er = 2'b00;
                if (sbq.size() == 0 && ifm.req_valid != 2'b00) begin
                    g  = winner(ifm.req_valid, model_last);
                    er = g ? 2'b10 : 2'b01;
                    e.id   = g;
                    e.data = g ? ref_alu(ifm.req1_opc, ifm.req1_a, ifm.req1_b, ifm.req1_c)
                               : ref_alu(ifm.req0_opc, ifm.req0_a, ifm.req0_b, ifm.req0_c);
                    e.zer  = (e.data == 16'h0000);
                    e.neg  = e.data[15];
                    e.due  = cyc + 2;
                    sbq.push_back(e);
                end
                checkOutput("req_ready", ifm.req_ready, er);
            end
        end
    end

    // Monitor: compares the presented response against the queue head.
    initial begin
        logic exp_valid;
        logic exp_busy;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                checkOutput("reset_rsp_valid", ifm.rsp_valid, 1'b0);
                checkOutput("reset_rsp_data", ifm.rsp_data, 16'h0);
                checkOutput("reset_rsp_id", ifm.rsp_id, 1'b0);
                checkOutput("reset_rsp_flags", {ifm.rsp_zer, ifm.rsp_neg}, 2'b00);
                checkOutput("reset_busy", busy, 1'b0);
                checkOutput("reset_op_count", op_count, 16'h0);
                checkOutput("reset_op_count_sat", op_count_s, 2'd0);
            end else begin
                exp_valid = (sbq.size() > 0) && (cyc >= sbq[0].due);
                exp_busy  = (sbq.size() > 0) && (cyc >= sbq[0].due - 1);
                checkOutput("rsp_valid", ifm.rsp_valid, exp_valid);
                checkOutput("busy", busy, exp_busy);
                checkOutput("op_count", op_count, (model_count > 65535) ? 65535 : model_count);
                checkOutput("op_count_sat", op_count_s, (model_count > 3) ? 3 : model_count);
                if (exp_valid) begin
                    e = sbq[0];
                    checkOutput("rsp_id", ifm.rsp_id, e.id);
                    checkOutput("rsp_data", ifm.rsp_data, e.data);
                    checkOutput("rsp_zer", ifm.rsp_zer, e.zer);
                    checkOutput("rsp_neg", ifm.rsp_neg, e.neg);
                    if (ifm.rsp_ready) begin
                        void'(sbq.pop_front());
                        done_q.push_back(e);
                        model_last = e.id;
                        model_count++;
                    end
                end
            end
        end
    end

    initial begin
        int n0;
        logic [1:0] v;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        flushModel();
        rst_n = 1'b1;
        driveInputs(2'b00, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #6;

        // Single requester, carry-in addition that wraps negative.
        driveInputs(2'b01, 3'd2, 16'h7FFF, 16'h0001, 1'b1, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idle(4, 1'b1);
        checkOutput("t1_count", done_q.size(), 1);
        checkOutput("t1_data", done_q[$].data, 16'h8001);
        checkOutput("t1_flags", {done_q[$].zer, done_q[$].neg}, 2'b01);
        checkOutput("t1_id", done_q[$].id, 1'b0);
        checkOutput("t1_op_count", op_count, 16'd1);

        // Continuous contention from reset alternates starting with FIRST_PRIO.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        flushModel();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        n0 = done_q.size();
        repeat (12) applyStimulus(2'b11, 3'd0, 16'h0005, 16'h0, 1'b0, 3'd3, 16'h0010, 16'hFFF0, 1'b0, 1'b1);
        idle(3, 1'b1);
        checkOutput("t2_count", done_q.size(), n0 + 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_order", done_q[n0 + k].id, k[0]);
            checkOutput("t2_data", done_q[n0 + k].data, k[0] ? 16'h0008 : 16'hFFFB);
        end

        // Backpressure while the other requesters keep asking.
        n0 = done_q.size();
        applyStimulus(2'b01, 3'd1, 16'h1234, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (7) applyStimulus(2'b11, 3'd5, 16'h0F0F, 16'h00F0, 1'b0, 3'd4, 16'hFFFF, 16'h1111, 1'b0, 1'b0);
        checkOutput("t3_busy", busy, 1'b1);
        checkOutput("t3_ready_blocked", ifm.req_ready, 2'b00);
        checkOutput("t3_held_data", ifm.rsp_data, 16'h1235);
        applyStimulus(2'b00, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkOutput("t3_one_completion", done_q.size(), n0 + 1);

        // Zero-producing and byte-mix opcodes.
        applyStimulus(2'b01, 3'd4, 16'h00FF, 16'hFF00, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkOutput("t4_and_data", done_q[$].data, 16'h0000);
        checkOutput("t4_and_zer", done_q[$].zer, 1'b1);
        applyStimulus(2'b10, 3'd0, 16'h0, 16'h0, 1'b0, 3'd6, 16'h12AB, 16'h34CD, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkOutput("t4_mix_data", done_q[$].data, 16'hABCD);
        checkOutput("t4_mix_id", done_q[$].id, 1'b1);
        applyStimulus(2'b01, 3'd7, 16'h5555, 16'hAAAA, 1'b1, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkOutput("t4_zero_op", {done_q[$].data, done_q[$].zer}, {16'h0000, 1'b1});

        // Reset during EXEC, then during RESP.
        applyStimulus(2'b01, 3'd1, 16'h0100, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        resetMidFlight(done_q.size());
        applyStimulus(2'b10, 3'd0, 16'h0, 16'h0, 1'b0, 3'd1, 16'h0200, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        resetMidFlight(done_q.size());

        // Randomised traffic; also walks the 2-bit counter into saturation.
        repeat (400) begin
            v = 2'($urandom_range(0, 3));
            applyStimulus(v,
                          3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                          3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                          $urandom_range(0, 3) != 0);
        end
        idle(6, 1'b1);
        checkOutput("drain_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
